// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial N-bit subtractor: a single full-subtract cell is stepped over
// WIDTH cycles, LSB first. The controller captures the operands, carries the
// borrow from one bit to the next, assembles the result and raises a one-cycle
// done pulse when the result is published.

// One-bit half subtractor: x - y.
module half_substractor (
    input  logic x,
    input  logic y,
    output logic d,
    output logic b
);
    assign d = x ^ y;
    assign b = ~x & y;
endmodule

module serial_subtractor_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);
    // One extra bit so the counter can reach WIDTH without wrapping.
    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_sh_q, res_sh_d;
    logic             brw_q, brw_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_out_q, borrow_out_d;

    logic             hs0_d, hs0_b, hs1_b;
    logic             cell_d, cell_bout;
    logic [WIDTH-1:0] res_shift;

    // Full subtractor: (a - b) first, then subtract the incoming borrow.
    half_substractor u_hs0 (
        .x (a_sh_q[0]),
        .y (b_sh_q[0]),
        .d (hs0_d),
        .b (hs0_b)
    );

    half_substractor u_hs1 (
        .x (hs0_d),
        .y (brw_q),
        .d (cell_d),
        .b (hs1_b)
    );

    assign cell_bout = hs0_b | hs1_b;

    // Result register with the new diff bit entering at the MSB side; after
    // WIDTH shifts the first (LSB) bit has reached position 0.
    always_comb begin
        res_shift            = res_sh_q >> 1;
        res_shift[WIDTH-1]   = cell_d;
    end

    // Next-state and datapath sequencing.
    always_comb begin
        state_d      = state_q;
        a_sh_d       = a_sh_q;
        b_sh_d       = b_sh_q;
        res_sh_d     = res_sh_q;
        brw_d        = brw_q;
        cnt_d        = cnt_q;
        diff_d       = diff_q;
        borrow_out_d = borrow_out_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_RUN;
                    a_sh_d   = a;
                    b_sh_d   = b;
                    brw_d    = 1'b0;
                    cnt_d    = '0;
                    res_sh_d = '0;
                end
            end
            S_RUN: begin
                res_sh_d = res_shift;
                brw_d    = cell_bout;
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    // Publish only the finished word; partial shifts stay internal.
                    state_d      = S_DONE;
                    diff_d       = res_shift;
                    borrow_out_d = cell_bout;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and data registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            a_sh_q       <= '0;
            b_sh_q       <= '0;
            res_sh_q     <= '0;
            brw_q        <= 1'b0;
            cnt_q        <= '0;
            diff_q       <= '0;
            borrow_out_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_sh_q       <= a_sh_d;
            b_sh_q       <= b_sh_d;
            res_sh_q     <= res_sh_d;
            brw_q        <= brw_d;
            cnt_q        <= cnt_d;
            diff_q       <= diff_d;
            borrow_out_q <= borrow_out_d;
        end
    end

    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign diff       = diff_q;
    assign borrow_out = borrow_out_q;

endmodule

// File: doc/serial_subtractor_ctrl.md
# serial_subtractor_ctrl

Bit-serial multi-bit subtractor controller that computes `a - b` for WIDTH-bit operands by sequencing one 1-bit subtract cell over WIDTH clock cycles, LSB first. The cell is a full subtractor built from two `half_substractor` instances plus an OR of their borrows. The controller owns operand capture, the borrow-chain register, the bit counter, result assembly and a start/done handshake. It is the sequencer that turns the existing 1-bit subtractor datapath into a usable N-bit unit.

## Interface
- `WIDTH`, default 8: operand and result width in bits. Legal range is WIDTH ≥ 1.
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: synchronous, active-low reset.
- `start`, input, 1: request a subtraction. Sampled only in IDLE.
- `a`, input, WIDTH: minuend. Captured on the accepting edge.
- `b`, input, WIDTH: subtrahend. Captured on the accepting edge.
- `busy`, output, 1: high whenever the state is not IDLE.
- `done`, output, 1: one-cycle pulse when `diff`/`borrow_out` update.
- `diff`, output, WIDTH: result `(a - b) mod 2^WIDTH`. Held between completions.
- `borrow_out`, output, 1: final borrow. It is 1 iff a < b as unsigned values.

## Operation
- The FSM has three states: IDLE, RUN and DONE.
- **IDLE**
  - If `start` = 1 at an edge: load `a_sh` ← a and `b_sh` ← b, clear the borrow register, clear the bit counter, clear the result shift register, and go to RUN.
  - Otherwise stay in IDLE.
- **RUN**, per edge:
  - Cell inputs are `a_sh[0]`, `b_sh[0]` and the borrow register.
  - The cell diff bit shifts into the result register MSB side, so after WIDTH shifts bit 0 sits at the LSB.
  - The borrow register takes the cell borrow.
  - `a_sh` and `b_sh` shift right by 1.
  - The counter increments.
  - On the edge where counter = WIDTH-1, go to DONE and also load `diff` ← final result and `borrow_out` ← final cell borrow.
- **DONE**: lasts exactly one cycle and returns to IDLE unconditionally. `start` is ignored here.
- **Cell equations**:
  - d = a ⊕ b ⊕ bin
  - bout = (¬a·b) | (¬(a⊕b)·bin)
- **Output behaviour**:
  - `diff` and `borrow_out` change only on the RUN→DONE edge or at reset.
  - Intermediate shift contents are never visible on `diff`.
- **Start outside IDLE**: `start` while `busy` = 1 has no effect. It is not queued.
- **Operand stability**: changes on `a`/`b` after the accepting edge do not affect the result.
- **Reset**: `rst_n` = 0 at any edge, including mid-RUN, forces the following:
  - state = IDLE, counter = 0, borrow register = 0;
  - `busy` = 0, `done` = 0, `diff` = 0, `borrow_out` = 0.
  - Any in-flight operation is discarded and no `done` is produced for it.
- **Counter width**: $clog2(WIDTH)+1 bits. No wrap occurs within an operation.
- **WIDTH = 1**: RUN lasts exactly one edge.

## Timing
- Edge 0 is the IDLE edge with `start` = 1.
  - `busy` = 1 from after edge 0.
  - Edges 1..WIDTH perform the WIDTH bit-steps; RUN→DONE happens on edge WIDTH.
  - `done` = 1 and the new `diff`/`borrow_out` are valid from after edge WIDTH.
  - On edge WIDTH+1: `done` = 0, `busy` = 0, state = IDLE.
- **Latency**: WIDTH edges from accept to `done`.
- **Throughput**: one operation per WIDTH+2 edges. With `start` held high, the next accept occurs at edge WIDTH+2.
- **Outputs**: all are registered. There are no combinational paths from inputs to outputs.
- **Values after reset release**: all outputs are 0. `busy` rises only after an accepted start.

## Test plan
- **Basic subtraction**: reset, WIDTH = 8, a = 0x05, b = 0x03, pulse `start` → `done` exactly 8 edges after accept, `diff` = 0x02, `borrow_out` = 0. `busy` high for 9 cycles.
- **Borrow cases**:
  - a = 0x03, b = 0x05 → `diff` = 0xFE, `borrow_out` = 1.
  - a = 0x00, b = 0x01 → `diff` = 0xFF, `borrow_out` = 1.
  - a = 0xFF, b = 0xFF → `diff` = 0x00, `borrow_out` = 0.
- **Ignored start and operand capture**: start a = 0x80, b = 0x01, then pulse `start` with a = 0x10, b = 0x20 at edges 3 and WIDTH+1 (DONE) → a single `done`, `diff` = 0x7F. No second operation begins until IDLE plus a new `start`.
- **Reset mid-operation**: start a = 0x55, b = 0x22, then assert `rst_n` = 0 at edge 4 → after that edge `busy` = 0, `diff` = 0, `borrow_out` = 0, and no `done` pulse ever appears. A subsequent start a = 0x0A, b = 0x0A gives `diff` = 0x00, `borrow_out` = 0.
- **Back-to-back with `start` held high**: two operations (a = 0x10, b = 0x01 then a = 0x01, b = 0x10) → `done` at edges 8 and 18, `diff` = 0x0F then 0xF1 (`borrow_out` 0 then 1). `diff` holds 0x0F between the two done pulses.
- **Exhaustive reference check**: WIDTH = 1 and WIDTH = 3 build, all a/b pairs → results match `(a - b) mod 2^WIDTH` and borrow = (a < b). Latency equals WIDTH edges.
